calc_seq_ctrl: RTL and testbench

Sequential keypad control unit for the calculator datapath. It accepts one key code per handshake, tracks operand entry, the operator, execution and result states, and issues one-cycle 2-bit control codes to the datapath: hold, shift digit, execute and clear. It generalises the combinational control decoder with a configurable operand digit count, a ready/valid key handshake, an ALU completion handshake, chained operators and sticky error handling.

---
 rtl/calc_seq_ctrl_if.sv | 23 ++
 rtl/calc_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_calc_seq_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if: keypad handshake, ALU handshake and datapath control bundle for calc_seq_ctrl
interface calc_seq_ctrl_if #(
  parameter int NDW = 3
);
  logic [3:0] key;
  logic key_vld;
  logic key_rdy;
  logic alu_done;
  logic alu_err;
  logic [1:0] cont;
  logic sel_b;
  logic [1:0] op;
  logic [NDW-1:0] ndig;
  logic err;
  modport master (
    output key, key_vld, alu_done, alu_err,
    input  key_rdy, cont, sel_b, op, ndig, err
  );
  modport slave (
    input  key, key_vld, alu_done, alu_err,
    output key_rdy, cont, sel_b, op, ndig, err
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: sequential keypad control unit issuing registered control codes to the calculator datapath.
// Optional feature macro CALC_REPEAT_EQ_EN: '=' on a shown result re-executes the last operation.
module calc_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int NDW = $clog2(DIGITS + 1)
) (
  input logic clk,
  input logic rst,
  calc_seq_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_A, S_OP, S_B, S_EXEC, S_RES, S_LOAD} state_t;
  state_t state, state_n;
  logic [1:0] cont_n, op_n, pend, pend_n, kop;
  logic sel_n, err_n, to_op, to_op_n;
  logic [NDW-1:0] ndig_n;
  logic acc, is_dig, is_op, is_eq, is_clr, room;
  assign bus.key_rdy = (state != S_EXEC) && (state != S_LOAD);
  assign acc = bus.key_vld && bus.key_rdy;
  assign is_dig = bus.key < 4'd10;
  assign is_op = (bus.key >= 4'd10) && (bus.key <= 4'd13);
  assign is_eq = bus.key == 4'd14;
  assign is_clr = bus.key == 4'd15;
  assign kop = bus.key[1:0] - 2'd2;
  assign room = bus.ndig < NDW'(DIGITS);
  always_comb begin
    state_n = state;
    cont_n = 2'b00;
    sel_n = bus.sel_b;
    op_n = bus.op;
    ndig_n = bus.ndig;
    err_n = bus.err;
    pend_n = pend;
    to_op_n = to_op;
    if (state == S_EXEC) begin
      // the cont=10 cycle itself never completes the operation
      if (bus.alu_done && bus.cont != 2'b10) begin
        err_n = bus.err | bus.alu_err;
        state_n = to_op ? S_OP : S_RES;
        op_n = to_op ? pend : bus.op;
        ndig_n = to_op ? '0 : bus.ndig;
      end
    end else if (state == S_LOAD) begin
      cont_n = 2'b01;
      sel_n = 1'b0;
      ndig_n = NDW'(1);
      state_n = S_A;
    end else if (acc && is_clr) begin
      cont_n = 2'b11;
      ndig_n = '0;
      sel_n = 1'b0;
      err_n = 1'b0;
      state_n = S_A;
    end else if (acc && !bus.err) begin
      case (state)
        S_A: begin
          if (is_dig) begin
            cont_n = room ? 2'b01 : 2'b00;
            ndig_n = room ? bus.ndig + NDW'(1) : bus.ndig;
            err_n = !room;
          end else if (is_op) begin
            op_n = kop;
            sel_n = 1'b1;
            ndig_n = '0;
            state_n = S_OP;
          end
        end
        S_OP: begin
          if (is_dig) begin
            cont_n = 2'b01;
            ndig_n = NDW'(1);
            state_n = S_B;
          end else if (is_op) begin
            op_n = kop;
          end else if (is_eq) begin
            err_n = 1'b1;
          end
        end
        S_B: begin
          if (is_dig) begin
            cont_n = room ? 2'b01 : 2'b00;
            ndig_n = room ? bus.ndig + NDW'(1) : bus.ndig;
            err_n = !room;
          end else begin
            // a chained operator executes first and is latched only on completion
            cont_n = 2'b10;
            pend_n = is_op ? kop : pend;
            to_op_n = is_op;
            state_n = S_EXEC;
          end
        end
        S_RES: begin
          if (is_dig) begin
            cont_n = 2'b11;
            state_n = S_LOAD;
          end else if (is_op) begin
            op_n = kop;
            sel_n = 1'b1;
            ndig_n = '0;
            state_n = S_OP;
          end
`ifdef CALC_REPEAT_EQ_EN
          else if (is_eq) begin
            cont_n = 2'b10;
            to_op_n = 1'b0;
            state_n = S_EXEC;
          end
`endif
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_A;
      bus.cont <= 2'b00;
      bus.sel_b <= 1'b0;
      bus.op <= 2'b00;
      bus.ndig <= '0;
      bus.err <= 1'b0;
      pend <= 2'b00;
      to_op <= 1'b0;
    end else begin
      state <= state_n;
      bus.cont <= cont_n;
      bus.sel_b <= sel_n;
      bus.op <= op_n;
      bus.ndig <= ndig_n;
      bus.err <= err_n;
      pend <= pend_n;
      to_op <= to_op_n;
    end
  end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: table-driven key sequences with a control-code scoreboard for calc_seq_ctrl.
module tb_calc_seq_ctrl;
  typedef struct {
    logic [3:0] k;
    logic [1:0] ec;
    logic [1:0] ec2;
    int dl;
    logic ae;
    logic sel;
    logic [1:0] op;
    logic [2:0] nd;
    logic er;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [1:0] sbq[$];
  vec_t vt[$];
  vec_t r;
  calc_seq_ctrl_if #(.NDW(3)) b();
  calc_seq_ctrl #(.DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(b.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && b.cont != 2'b00) begin
      if (sbq.size() == 0) chk("cont_unexpected", 8'(b.cont), 8'h0);
      else chk("cont", 8'(b.cont), 8'(sbq.pop_front()));
    end
  end
  task automatic press(input vec_t v);
    int n = 0;
    @(negedge clk);
    while (!b.key_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!b.key_rdy) chk("rdy_wait", 8'(b.key_rdy), 8'h1);
    b.key = v.k;
    b.key_vld = 1'b1;
    if (v.ec != 2'b00) sbq.push_back(v.ec);
    @(posedge clk);
    #1 b.key_vld = 1'b0;
    if (v.ec2 != 2'b00) begin
      sbq.push_back(v.ec2);
      chk("rdy_load", 8'(b.key_rdy), 8'h0);
      @(posedge clk);
      #1;
    end
    if (v.dl > 0) begin
      repeat (v.dl) @(posedge clk);
      @(negedge clk);
      chk("rdy_exec", 8'(b.key_rdy), 8'h0);
      b.alu_done = 1'b1;
      b.alu_err = v.ae;
      @(posedge clk);
      #1 b.alu_done = 1'b0;
      b.alu_err = 1'b0;
    end
    chk($sformatf("sel_b k=%0d", v.k), 8'(b.sel_b), 8'(v.sel));
    chk($sformatf("op k=%0d", v.k), 8'(b.op), 8'(v.op));
    chk($sformatf("ndig k=%0d", v.k), 8'(b.ndig), 8'(v.nd));
    chk($sformatf("err k=%0d", v.k), 8'(b.err), 8'(v.er));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    b.key = 4'd0;
    b.key_vld = 1'b0;
    b.alu_done = 1'b0;
    b.alu_err = 1'b0;
    // k, ec, ec2, dl, ae, sel_b, op, ndig, err
    vt.push_back('{4'd1, 2'b01, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0});
    vt.push_back('{4'd2, 2'b01, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0});
    vt.push_back('{4'd10, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0});
    vt.push_back('{4'd3, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    vt.push_back('{4'd14, 2'b10, 2'b00, 2, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
`ifdef CALC_REPEAT_EQ_EN
    vt.push_back('{4'd14, 2'b10, 2'b00, 1, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
`else
    vt.push_back('{4'd14, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
`endif
    vt.push_back('{4'd7, 2'b11, 2'b01, 0, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0});
    vt.push_back('{4'd12, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b0});
    vt.push_back('{4'd2, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd2, 3'd1, 1'b0});
    vt.push_back('{4'd11, 2'b10, 2'b00, 3, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0});
    vt.push_back('{4'd10, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0});
    vt.push_back('{4'd14, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b1});
    vt.push_back('{4'd5, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b1});
    vt.push_back('{4'd15, 2'b11, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0});
    vt.push_back('{4'd14, 2'b00, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0});
    for (int i = 1; i <= 4; i++)
      vt.push_back('{4'(i), 2'b01, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'(i), 1'b0});
    vt.push_back('{4'd5, 2'b00, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1});
    vt.push_back('{4'd10, 2'b00, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd4, 1'b1});
    vt.push_back('{4'd15, 2'b11, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0});
    vt.push_back('{4'd5, 2'b01, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0});
    vt.push_back('{4'd12, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b0});
    vt.push_back('{4'd2, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd2, 3'd1, 1'b0});
    vt.push_back('{4'd11, 2'b10, 2'b00, 1, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0});
    vt.push_back('{4'd3, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0});
    vt.push_back('{4'd14, 2'b10, 2'b00, 2, 1'b1, 1'b1, 2'd1, 3'd1, 1'b1});
    vt.push_back('{4'd7, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b1});
    vt.push_back('{4'd10, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b1});
    vt.push_back('{4'd15, 2'b11, 2'b00, 0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0});
    vt.push_back('{4'd4, 2'b01, 2'b00, 0, 1'b0, 1'b0, 2'd1, 3'd1, 1'b0});
    vt.push_back('{4'd10, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0});
    vt.push_back('{4'd6, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    vt.push_back('{4'd14, 2'b10, 2'b00, 1, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0});
    vt.push_back('{4'd13, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0});
    vt.push_back('{4'd8, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd3, 3'd1, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_cont", 8'(b.cont), 8'h0);
    chk("rst_sel_b", 8'(b.sel_b), 8'h0);
    chk("rst_op", 8'(b.op), 8'h0);
    chk("rst_ndig", 8'(b.ndig), 8'h0);
    chk("rst_err", 8'(b.err), 8'h0);
    chk("rst_key_rdy", 8'(b.key_rdy), 8'h1);
    foreach (vt[i]) press(vt[i]);
    // alu_done during the cont=10 cycle must not finish the execution
    @(negedge clk);
    b.key = 4'd14;
    b.key_vld = 1'b1;
    sbq.push_back(2'b10);
    @(posedge clk);
    #1 b.key_vld = 1'b0;
    b.alu_done = 1'b1;
    @(posedge clk);
    #1 b.alu_done = 1'b0;
    chk("early_done_ignored", 8'(b.key_rdy), 8'h0);
    @(negedge clk);
    b.alu_done = 1'b1;
    @(posedge clk);
    #1 b.alu_done = 1'b0;
    chk("exec_exit", 8'(b.key_rdy), 8'h1);
    r = '{4'd10, 2'b00, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0};
    press(r);
    r = '{4'd1, 2'b01, 2'b00, 0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0};
    press(r);
    @(negedge clk);
    b.key = 4'd11;
    b.key_vld = 1'b1;
    sbq.push_back(2'b10);
    @(posedge clk);
    #1 b.key_vld = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_cont", 8'(b.cont), 8'h0);
    chk("mid_rst_sel_b", 8'(b.sel_b), 8'h0);
    chk("mid_rst_op", 8'(b.op), 8'h0);
    chk("mid_rst_ndig", 8'(b.ndig), 8'h0);
    chk("mid_rst_key_rdy", 8'(b.key_rdy), 8'h1);
    @(negedge clk);
    b.alu_done = 1'b1;
    @(posedge clk);
    #1 b.alu_done = 1'b0;
    chk("late_done_rdy", 8'(b.key_rdy), 8'h1);
    chk("late_done_op", 8'(b.op), 8'h0);
    r = '{4'd9, 2'b01, 2'b00, 0, 1'b0, 1'b0, 2'd0, 3'd1, 1'b0};
    press(r);
    repeat (3) @(posedge clk);
    chk("sb_empty", 8'(sbq.size()), 8'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
